// File: rtl/flex_enable_pkg.sv
// flex_enable_pkg: shared types and helpers for the flex enable rate adapter.
//   mode_t  - SHRINK (one-cycle pulse per event) or STRETCH (fixed-width pulse per event)
//   edge_t  - qualifying edge of the synchronised enable
//   state_t - per-channel stretch FSM states
package flex_enable_pkg;

  typedef enum logic {SHRINK, STRETCH} mode_t;

  typedef enum logic [1:0] {RISE, FALL, BOTH} edge_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flex_enable_chan.sv
// flex_enable_chan: one channel of the enable rate adapter.
// Synchronises enable_in, detects the selected edge and either emits a
// registered one-cycle pulse (SHRINK) or a STRETCH_LEN-cycle pulse per event
// with GAP_LEN low cycles between queued pulses (STRETCH).
// Ports:
//   clk        in  system clock
//   n_rst      in  asynchronous active-low reset
//   enable_in  in  raw enable (async or slow domain)
//   clear      in  synchronous clear of pending count and overflow flag
//   enable_out out adapted enable
//   overflow   out sticky: an event was dropped because the queue was full
module flex_enable_chan
  import flex_enable_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter mode_t MODE        = SHRINK,
  parameter edge_t EDGE        = RISE,
  parameter int    STRETCH_LEN = 4,
  parameter int    GAP_LEN     = 1,
  parameter int    MAX_PEND    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_in,
  input  logic clear,
  output logic enable_out,
  output logic overflow
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int CW = $clog2(max3(STRETCH_LEN, GAP_LEN, 1) + 1);
  localparam logic [CW-1:0] LEN_M1 = CW'(STRETCH_LEN - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  logic                 s, s_d, raw_evt, evt, pulse_q;
  logic [SYNC_STAGES:0] vld;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        chain <= '0;
      end else begin
        chain[0] <= enable_in;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
    end
    assign s = chain[SYNC_STAGES-1];
  end else begin : g_nosync
    assign s = enable_in;
  end

  // vld tracks which pipeline stages hold real post-reset samples; an edge is
  // only trusted once s_d is valid, so a level already high at reset release
  // fills the chain without looking like a rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_d     <= 1'b0;
      vld     <= '0;
      pulse_q <= 1'b0;
    end else begin
      s_d     <= s;
      vld[0]  <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) vld[i] <= vld[i-1];
      pulse_q <= evt;
    end
  end

  always_comb begin
    case (EDGE)
      RISE:    raw_evt = s & ~s_d;
      FALL:    raw_evt = ~s & s_d;
      default: raw_evt = s ^ s_d;
    endcase
  end

  assign evt = raw_evt & vld[SYNC_STAGES];

  // ---------------- stretch FSM ----------------
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pending, pending_n, pend_base;
  logic          ovf_q, ovf_n, decide, busy;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      ovf_q   <= ovf_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    decide    = 1'b0;
    pend_base = clear ? '0 : pending;
    pending_n = pend_base;
    ovf_n     = clear ? 1'b0 : ovf_q;

    case (state)
      IDLE: begin
        if (evt) begin
          state_n = ACTIVE;
          cnt_n   = LEN_M1;
        end
      end
      ACTIVE: begin
        if (cnt == '0) begin
          if (GAP_LEN > 0) begin
            state_n = GAP;
            cnt_n   = GAP_M1;
          end else begin
            decide = 1'b1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) decide = 1'b1;
        else           cnt_n  = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase

    // Next-pulse decision: a queued event, or one arriving this very cycle,
    // launches the next pulse with no idle cycle in between.
    if (decide) begin
      if (pend_base != '0 || evt) begin
        state_n = ACTIVE;
        cnt_n   = LEN_M1;
      end else begin
        state_n = IDLE;
      end
      if (pend_base != '0) pending_n = pend_base - PW'(1);
    end

    // An event while busy is queued; on a dequeue cycle it simply takes the
    // slot being consumed (or launches the pulse directly if nothing queued).
    if (busy && evt) begin
      if (decide) begin
        pending_n = pend_base;
      end else if (pend_base == PW'(MAX_PEND)) begin
        ovf_n = 1'b1;
      end else begin
        pending_n = pend_base + PW'(1);
      end
    end
  end

  assign enable_out = (MODE == STRETCH) ? (state == ACTIVE) : pulse_q;
  assign overflow   = (MODE == STRETCH) ? ovf_q : 1'b0;

endmodule

// File: rtl/flex_enable_adapter.sv
// flex_enable_adapter: NUM_CH independent enable rate adapters sharing clear.
// Ports:
//   clk        in  system clock
//   n_rst      in  asynchronous active-low reset
//   enable_in  in  [NUM_CH] raw enables, one bit per channel
//   clear      in  synchronous clear of every channel's pending count and overflow
//   enable_out out [NUM_CH] adapted enables
//   overflow   out [NUM_CH] sticky dropped-event flags
module flex_enable_adapter
  import flex_enable_pkg::*;
#(
  parameter int    NUM_CH      = 4,
  parameter int    SYNC_STAGES = 2,
  parameter mode_t MODE        = SHRINK,
  parameter edge_t EDGE        = RISE,
  parameter int    STRETCH_LEN = 4,
  parameter int    GAP_LEN     = 1,
  parameter int    MAX_PEND    = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] enable_in,
  input  logic              clear,
  output logic [NUM_CH-1:0] enable_out,
  output logic [NUM_CH-1:0] overflow
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flex_enable_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE),
      .EDGE        (EDGE),
      .STRETCH_LEN (STRETCH_LEN),
      .GAP_LEN     (GAP_LEN),
      .MAX_PEND    (MAX_PEND)
    ) u_chan (
      .clk        (clk),
      .n_rst      (n_rst),
      .enable_in  (enable_in[i]),
      .clear      (clear),
      .enable_out (enable_out[i]),
      .overflow   (overflow[i])
    );
  end

endmodule
